// File: rtl/arilla_sb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arilla_sb_pkg : shared types and helpers for the SBA bus initiator       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package arilla_sb_pkg;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_REQ  = 2'd1,
    SB_RSP  = 2'd2
  } sb_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } sb_size_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_TIMEOUT   = 3'd1,
    ERR_INTERCEPT = 3'd2,
    ERR_MISALIGN  = 3'd3,
    ERR_SIZE      = 3'd4
  } sb_error_t;

  function automatic logic [3:0] size_mask(input sb_size_t s);
    logic [3:0] m;
    case (s)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] lo, input sb_size_t s);
    logic r;
    case (s)
      SZ_HALF: r = lo[0];
      SZ_WORD: r = |lo;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arilla_bus_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arilla_bus_if : single-beat system bus between initiators and responders |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface arilla_bus_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int ByteSize     = 8
);
  localparam int NumLanes = DataWidth / ByteSize;

  logic [AddressWidth-1:0] addr;
  logic [DataWidth-1:0]    wdata;
  logic [NumLanes-1:0]     be;
  logic                    rd;
  logic                    wr;
  logic [DataWidth-1:0]    rdata;
  logic                    inhibit;
  logic                    intercept;

  modport initiator (output addr, wdata, be, rd, wr, input rdata, inhibit, intercept);
  modport responder (input addr, wdata, be, rd, wr, output rdata, inhibit, intercept);
endinterface
`default_nettype wire

// File: rtl/arilla_sb_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arilla_sb_lane : byte-lane steering for writes and read extraction       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module arilla_sb_lane
  import arilla_sb_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int ByteSize     = 8
) (
  input  wire logic [AddressWidth-1:0]         addr_i,
  input  wire logic [1:0]                      size_i,
  input  wire logic [DataWidth-1:0]            wdata_i,
  input  wire logic [DataWidth-1:0]            bus_rdata_i,
  output logic [AddressWidth-1:0]              word_addr_o,
  output logic [DataWidth/ByteSize-1:0]        be_o,
  output logic [DataWidth-1:0]                 wdata_o,
  output logic [DataWidth-1:0]                 rdata_o
);
  localparam int NumLanes = DataWidth / ByteSize;
  localparam int OffW     = $clog2(NumLanes);

  logic [OffW-1:0]      off;
  logic [NumLanes-1:0]  size_be;
  logic [DataWidth-1:0] size_bits;

  assign off     = addr_i[OffW-1:0];
  assign size_be = NumLanes'(size_mask(sb_size_t'(size_i)));

  // Bit mask covering the right-aligned bytes of the transfer size.
  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    assign size_bits[i*ByteSize +: ByteSize] = {ByteSize{size_be[i]}};
  end

  assign word_addr_o = {addr_i[AddressWidth-1:OffW], OffW'(0)};
  assign be_o        = size_be << off;
  assign wdata_o     = (wdata_i & size_bits) << (int'(off) * ByteSize);
  assign rdata_o     = (bus_rdata_i >> (int'(off) * ByteSize)) & size_bits;

endmodule
`default_nettype wire

// File: rtl/arilla_sb_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arilla_sb_initiator : debug SBA command -> single-beat bus transfer      |
// | Optional ARILLA_SB_TIMEOUT_EN bounds inhibit wait-states. Revision 1.0   |
// +--------------------------------------------------------------------------+
module arilla_sb_initiator
  import arilla_sb_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int ByteSize      = 8,
  parameter int TimeoutCycles = 255
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    cmd_valid_i,
  output logic                         cmd_ready_o,
  input  wire logic                    cmd_write_i,
  input  wire logic [1:0]              cmd_size_i,
  input  wire logic [AddressWidth-1:0] cmd_addr_i,
  input  wire logic [DataWidth-1:0]    cmd_wdata_i,
  input  wire logic                    cmd_autoinc_i,
  output logic                         rsp_valid_o,
  input  wire logic                    rsp_ready_i,
  output logic [DataWidth-1:0]         rsp_rdata_o,
  output logic [2:0]                   rsp_error_o,
  output logic [AddressWidth-1:0]      rsp_next_addr_o,
  output logic                         busy_o,
  arilla_bus_if.initiator              bus
);
  localparam int NumLanes = DataWidth / ByteSize;

  sb_state_t               state_q, state_d;
  logic                    write_q, autoinc_q;
  sb_size_t                size_q;
  logic [AddressWidth-1:0] addr_q;
  logic [DataWidth-1:0]    wdata_q;
  logic [DataWidth-1:0]    rsp_rdata_q, rsp_rdata_d;
  sb_error_t               rsp_error_q, rsp_error_d;
  logic [AddressWidth-1:0] rsp_next_addr_q, rsp_next_addr_d;

  logic                    accept, in_req, timeout_hit;
  logic [AddressWidth-1:0] lane_addr, addr_inc;
  logic [NumLanes-1:0]     lane_be;
  logic [DataWidth-1:0]    lane_wdata, lane_rdata;

  arilla_sb_lane #(
    .DataWidth(DataWidth), .AddressWidth(AddressWidth), .ByteSize(ByteSize)
  ) u_lane (
    .addr_i(addr_q), .size_i(size_q), .wdata_i(wdata_q), .bus_rdata_i(bus.rdata),
    .word_addr_o(lane_addr), .be_o(lane_be), .wdata_o(lane_wdata), .rdata_o(lane_rdata)
  );

  assign accept   = cmd_valid_i & cmd_ready_o;
  assign in_req   = (state_q == SB_REQ);
  assign addr_inc = AddressWidth'(1) << size_q;

  // Bus outputs are gated by state so an async reset drops them at once.
  assign bus.rd    = in_req & ~write_q;
  assign bus.wr    = in_req & write_q;
  assign bus.addr  = in_req ? lane_addr  : '0;
  assign bus.be    = in_req ? lane_be    : '0;
  assign bus.wdata = in_req ? lane_wdata : '0;

`ifdef ARILLA_SB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else if (accept) begin
      wait_q <= '0;
    end else if (in_req && bus.inhibit && (wait_q != CntW'(TimeoutCycles))) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign timeout_hit = (wait_q == CntW'(TimeoutCycles));
`else
  logic unused_timeout;
  assign unused_timeout = (TimeoutCycles != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_error_d     = rsp_error_q;
    rsp_next_addr_d = rsp_next_addr_q;
    unique case (state_q)
      SB_IDLE: begin
        if (accept) begin
          rsp_rdata_d     = '0;
          rsp_next_addr_d = cmd_addr_i;
          if (sb_size_t'(cmd_size_i) == SZ_BAD) begin
            rsp_error_d = ERR_SIZE;
            state_d     = SB_RSP;
          end else if (is_misaligned(cmd_addr_i[1:0], sb_size_t'(cmd_size_i))) begin
            rsp_error_d = ERR_MISALIGN;
            state_d     = SB_RSP;
          end else begin
            rsp_error_d = ERR_NONE;
            state_d     = SB_REQ;
          end
        end
      end
      SB_REQ: begin
        if (!bus.inhibit) begin
          state_d = SB_RSP;
          if (bus.intercept) begin
            rsp_error_d = ERR_INTERCEPT;
            rsp_rdata_d = '0;
          end else begin
            rsp_error_d = ERR_NONE;
            rsp_rdata_d = write_q ? '0 : lane_rdata;
            if (autoinc_q) rsp_next_addr_d = addr_q + addr_inc;
          end
        end else if (timeout_hit) begin
          state_d     = SB_RSP;
          rsp_error_d = ERR_TIMEOUT;
        end
      end
      SB_RSP: begin
        if (rsp_ready_i) state_d = SB_IDLE;
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= SB_IDLE;
      write_q         <= 1'b0;
      size_q          <= SZ_BYTE;
      addr_q          <= '0;
      wdata_q         <= '0;
      autoinc_q       <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_error_q     <= ERR_NONE;
      rsp_next_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_error_q     <= rsp_error_d;
      rsp_next_addr_q <= rsp_next_addr_d;
      if (accept) begin
        write_q   <= cmd_write_i;
        size_q    <= sb_size_t'(cmd_size_i);
        addr_q    <= cmd_addr_i;
        wdata_q   <= cmd_wdata_i;
        autoinc_q <= cmd_autoinc_i;
      end
    end
  end

  assign cmd_ready_o     = (state_q == SB_IDLE);
  assign rsp_valid_o     = (state_q == SB_RSP);
  assign busy_o          = (state_q != SB_IDLE);
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_error_o     = rsp_error_q;
  assign rsp_next_addr_o = rsp_next_addr_q;

endmodule
`default_nettype wire
